// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 4;

    // Step counter must index bit positions 0..w-1; keep at least one bit.
    function automatic int mult_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one partial product per clock, start/ready in and done pulse out.
// Latency WIDTH cycles from the accepting edge; start is ignored while busy.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = mult_cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    mult_state_t     r_state;
    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_p;

    logic [PW-1:0]   w_addend;
    logic [PW-1:0]   w_acc_next;
    logic            w_last;

    // Addend is formed at full product width so the shifted multiplicand never truncates.
    assign w_addend   = r_mplier[0] ? (r_mcand << r_count) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_last     = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_p      <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_p     <= w_acc_next;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = (r_state == IDLE) || (r_state == DONE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign p     = r_p;

endmodule
